// File: rtl/ser2par_pkg.sv
// Shared types and frame-length helper for ser2par_hs.
// Build option: define SER2PAR_PARITY_EN to append one parity bit to every frame.
package ser2par_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef SER2PAR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int unsigned frame_len(input int unsigned width);
        return width + (PARITY_EN ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/ser2par_shreg.sv
// WIDTH-bit shift register with selectable entry side and running parity of the
// bits shifted in; shifted_o previews the value after shifting in bit_i.
module ser2par_shreg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] shifted_o,
    output logic             parity_o
);

    logic [WIDTH-1:0] data_q;
    logic             par_q;

    always_comb begin
        shifted_o = MSB_FIRST ? {data_q[WIDTH-2:0], bit_i} : {bit_i, data_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (clr_i) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (shift_i) begin
            data_q <= shifted_o;
            par_q  <= par_q ^ bit_i;
        end
    end

    assign data_o   = data_q;
    assign parity_o = par_q;

endmodule

// File: rtl/ser2par_hs.sv
// Serial-to-parallel converter with ready/valid output, abort and overrun flags.
// Build option: SER2PAR_PARITY_EN (see ser2par_pkg) enables a trailing parity bit.
module ser2par_hs
    import ser2par_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_abort,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned    FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned    CW        = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]  DATA_BITS = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             abort_q, abort_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic             sample, complete, shift_en;
    logic [WIDTH-1:0] sh_data, sh_shifted, word;
    logic             sh_par, word_perr;

    ser2par_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (start),
        .shift_i   (shift_en),
        .bit_i     (serial_in),
        .data_o    (sh_data),
        .shifted_o (sh_shifted),
        .parity_o  (sh_par)
    );

    always_comb begin
        sample   = (state_q == SHIFT) && bit_en;
        complete = sample && (cnt_q == LAST_IDX);
        // parity bit is counted but never enters the shift register
        shift_en = sample && !start && (cnt_q < DATA_BITS);
        abort_d  = (state_q == SHIFT) && start && !complete;
        // with parity the data bits are already stored when the parity bit arrives
        word      = PARITY_EN ? sh_data : sh_shifted;
        word_perr = PARITY_EN && ((sh_par ^ serial_in) != PARITY_ODD);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (complete) begin
                    state_d = start ? SHIFT : IDLE;
                    cnt_d   = '0;
                end else if (start) begin
                    cnt_d = '0;
                end else if (bit_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;
        if (complete) begin
            if (!valid_q || out_ready) begin
                data_d  = word;
                perr_d  = word_perr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out    = data_q;
    assign out_valid   = valid_q;
    assign frame_abort = abort_q;
    assign overrun     = ovr_q;
    assign parity_err  = perr_q;

endmodule

// File: tb/tb_ser2par_hs.sv
// Directed bench for ser2par_hs: MSB-first and LSB-first instances share stimulus.
module tb_ser2par_hs;
    import ser2par_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned FL = frame_len(W);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, start = 1'b0, bit_en = 1'b0, serial_in = 1'b0, out_ready = 1'b0;
    logic [7:0] dout_m, dout_l;
    logic       val_m, val_l, ab_m, ab_l, ov_m, ov_l, pe_m, pe_l;
    int         checks = 0;
    int         failures = 0;

    ser2par_hs #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_ODD(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .start(start), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(dout_m), .out_valid(val_m), .out_ready(out_ready),
        .frame_abort(ab_m), .overrun(ov_m), .parity_err(pe_m)
    );

    ser2par_hs #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_ODD(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .start(start), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(dout_l), .out_valid(val_l), .out_ready(out_ready),
        .frame_abort(ab_l), .overrun(ov_l), .parity_err(pe_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [7:0] em,
                           input logic [7:0] el, input logic eo);
        chk({name, ".valid_m"}, {31'd0, val_m}, {31'd0, ev});
        chk({name, ".valid_l"}, {31'd0, val_l}, {31'd0, ev});
        chk({name, ".data_m"}, {24'd0, dout_m}, {24'd0, em});
        chk({name, ".data_l"}, {24'd0, dout_l}, {24'd0, el});
        chk({name, ".overrun"}, {30'd0, ov_m, ov_l}, {30'd0, eo, eo});
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bits go out in w[7]..w[0] order, then the parity bit when the frame has one.
    task automatic send_bits(input logic [7:0] w, input int gap, input logic par,
                             input logic rdy_last, input logic start_last);
        for (int i = 0; i < int'(FL); i++) begin
            for (int g = 1; g < gap; g++) begin
                bit_en    = 1'b0;
                serial_in = 1'($urandom);
                tick();
            end
            bit_en    = 1'b1;
            serial_in = (i < int'(W)) ? w[7-i] : par;
            if (i == int'(FL) - 1) begin
                if (rdy_last) out_ready = 1'b1;
                start = start_last;
            end
            tick();
            start = 1'b0;
        end
        bit_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] w;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
        int         gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hB2, 8'hB2, 8'h4D, 1};
        vecs[1] = '{8'hB2, 8'hB2, 8'h4D, 3};
        vecs[2] = '{8'hA5, 8'hA5, 8'hA5, 1};
        vecs[3] = '{8'h01, 8'h01, 8'h80, 2};
        vecs[4] = '{8'hF0, 8'hF0, 8'h0F, 1};
        vecs[5] = '{8'h3C, 8'h3C, 8'h3C, 1};

        // reset state
        reset_n = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
        chk("reset.abort", {30'd0, ab_m, ab_l}, 32'd0);
        reset_n = 1'b1;
        tick();

        // table: single frames with consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            start_frame();
            send_bits(vecs[v].w, vecs[v].gap, ^vecs[v].w, 1'b0, 1'b0);
            chk_out($sformatf("vec%0d", v), 1'b1, vecs[v].exp_m, vecs[v].exp_l, 1'b0);
            chk($sformatf("vec%0d.abort", v), {30'd0, ab_m, ab_l}, 32'd0);
            chk($sformatf("vec%0d.perr", v), {30'd0, pe_m, pe_l}, 32'd0);
            tick();
            chk($sformatf("vec%0d.valid_drop", v), {30'd0, val_m, val_l}, 32'd0);
        end

        // overrun: second frame dropped while first is unconsumed
        out_ready = 1'b0;
        start_frame();
        send_bits(8'hA5, 1, ^8'hA5, 1'b0, 1'b0);
        chk_out("ovr.first", 1'b1, 8'hA5, 8'hA5, 1'b0);
        start_frame();
        send_bits(8'h3C, 1, ^8'h3C, 1'b0, 1'b0);
        chk_out("ovr.second", 1'b1, 8'hA5, 8'hA5, 1'b1);
        out_ready = 1'b1;
        tick();
        chk_out("ovr.accept", 1'b0, 8'hA5, 8'hA5, 1'b1);

        // reset in mid-frame with a pending word and sticky overrun
        out_ready = 1'b0;
        start_frame();
        send_bits(8'h5A, 1, ^8'h5A, 1'b0, 1'b0);
        start_frame();
        for (int i = 0; i < 5; i++) begin
            bit_en    = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        reset_n = 1'b0;
        tick();
        chk_out("midrst", 1'b0, 8'h00, 8'h00, 1'b0);
        chk("midrst.abort", {30'd0, ab_m, ab_l}, 32'd0);
        reset_n   = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b1;
        tick();
        start_frame();
        send_bits(8'h81, 1, ^8'h81, 1'b0, 1'b0);
        chk_out("post_rst", 1'b1, 8'h81, 8'h81, 1'b0);
        tick();

        // abort after 4 bits, then a full frame of ones
        start_frame();
        for (int i = 0; i < 4; i++) begin
            bit_en    = 1'b1;
            serial_in = 1'b0;
            tick();
        end
        start     = 1'b1;
        serial_in = 1'b1;
        tick();
        start  = 1'b0;
        bit_en = 1'b0;
        chk("abort.pulse", {30'd0, ab_m, ab_l}, 32'd3);
        chk("abort.valid", {30'd0, val_m, val_l}, 32'd0);
        tick();
        chk("abort.pulse_end", {30'd0, ab_m, ab_l}, 32'd0);
        send_bits(8'hFF, 1, ^8'hFF, 1'b0, 1'b0);
        chk_out("abort.frame", 1'b1, 8'hFF, 8'hFF, 1'b0);
        tick();

        // completion in the same cycle as acceptance
        out_ready = 1'b0;
        start_frame();
        send_bits(8'h11, 1, ^8'h11, 1'b0, 1'b0);
        start_frame();
        send_bits(8'h22, 1, ^8'h22, 1'b1, 1'b0);
        chk_out("acc_same", 1'b1, 8'h22, 8'h44, 1'b0);
        tick();
        chk("acc_same.drop", {30'd0, val_m, val_l}, 32'd0);

        // start in the completion cycle: word completes, next frame begins
        start_frame();
        send_bits(8'h0F, 1, ^8'h0F, 1'b0, 1'b1);
        chk_out("start_cpl", 1'b1, 8'h0F, 8'hF0, 1'b0);
        chk("start_cpl.abort", {30'd0, ab_m, ab_l}, 32'd0);
        tick();
        send_bits(8'hC1, 1, ^8'hC1, 1'b0, 1'b0);
        chk_out("start_cpl.next", 1'b1, 8'hC1, 8'h83, 1'b0);
        tick();

`ifdef SER2PAR_PARITY_EN
        start_frame();
        send_bits(8'h07, 1, 1'b1, 1'b0, 1'b0);
        chk("par.good", {30'd0, pe_m, pe_l}, 32'd0);
        tick();
        start_frame();
        send_bits(8'h07, 1, 1'b0, 1'b0, 1'b0);
        chk("par.bad", {30'd0, pe_m, pe_l}, 32'd3);
        chk_out("par.data", 1'b1, 8'h07, 8'hE0, 1'b0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
